dmem_responder: RTL and testbench

Data-memory responder for the MIPS datapath: it is the memory-side end of the CPU's load/store interface. It accepts one request per handshake, waits a fixed latency, and performs the access on an internal word array. Access width and load extension are selected by a 4-bit MemControl code. It returns the load data, or an error flag for misaligned or illegal accesses. It replaces the zero-latency data memory when the core is moved to a stalling, multi-cycle memory model.

---
 rtl/dmem_responder.sv | 113 +++++++++++
 tb/tb_dmem_responder.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MIPS load/store interface
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   req_valid/ready  : request handshake; ready is low only while BUSY
//   req_addr         : byte address (word index = addr[log2(DEPTH_WORDS)+1:2], upper bits wrap)
//   req_wdata        : right-aligned store data
//   req_memcontrol   : 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB, 8-15 illegal
//   resp_valid       : one-cycle response pulse, LATENCY cycles after accept
//   resp_rdata       : extended load data, 0 for stores and errors
//   resp_err         : misaligned access or illegal code
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_memcontrol,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t state, state_next;
    logic [3:0] cnt;
    logic [AW+1:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0] code_q;
    logic [31:0] mem [DEPTH_WORDS];
    logic accept, fire, we, err, size_word, size_half, is_store;
    logic [AW-1:0] idx;
    logic [1:0] off;
    logic [31:0] word, load_data, wd_sh;
    logic [7:0] lane_b;
    logic [15:0] lane_h;
    logic [3:0] be;
    logic unused_addr;

    assign unused_addr = ^req_addr[31:AW+2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_next;
    end

    // The RESP cycle accepts a new request just like IDLE, giving LATENCY+1 throughput.
    always_comb begin
        state_next = accept ? BUSY : fire ? RESP : (state == BUSY) ? BUSY : IDLE;
    end

    always_comb begin
        req_ready = state != BUSY;
        accept = req_valid & req_ready;
        fire = (state == BUSY) && (cnt == 4'd0);
    end

    always_comb begin
        idx = addr_q[AW+1:2];
        off = addr_q[1:0];
        word = mem[idx];
        size_word = (code_q == 4'd0) || (code_q == 4'd5);
        size_half = (code_q == 4'd1) || (code_q == 4'd2) || (code_q == 4'd6);
        is_store = (code_q == 4'd5) || (code_q == 4'd6) || (code_q == 4'd7);
        err = code_q[3] | (size_word & (off != 2'd0)) | (size_half & off[0]);
        lane_b = 8'(word >> {off, 3'b000});
        lane_h = off[1] ? word[31:16] : word[15:0];
        load_data = err ? 32'd0 :
                    (code_q == 4'd0) ? word :
                    (code_q == 4'd1) ? {{16{lane_h[15]}}, lane_h} :
                    (code_q == 4'd2) ? {16'd0, lane_h} :
                    (code_q == 4'd3) ? {{24{lane_b[7]}}, lane_b} :
                    (code_q == 4'd4) ? {24'd0, lane_b} : 32'd0;
        be = size_word ? 4'hf : size_half ? (off[1] ? 4'hc : 4'h3) : 4'b0001 << off;
        wd_sh = wdata_q << {off, 3'b000};
        we = fire & is_store & ~err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 4'd0;
            addr_q <= '0;
            wdata_q <= 32'd0;
            code_q <= 4'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err <= 1'b0;
        end else begin
            resp_valid <= fire;
            if (accept) begin
                addr_q <= req_addr[AW+1:0];
                wdata_q <= req_wdata;
                code_q <= req_memcontrol;
                cnt <= 4'(LATENCY - 1);
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (fire) begin
                resp_rdata <= load_data;
                resp_err <= err;
            end
        end
    end

    // The array has no reset; an async reset forces IDLE so a pending write never fires.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (we && be[b]) mem[idx][8*b +: 8] <= wd_sh[8*b +: 8];
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a byte-level model
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rv [2];
    logic rr [2];
    logic [31:0] ra [2];
    logic [31:0] rw [2];
    logic [3:0] rc [2];
    logic pv [2];
    logic [31:0] pd [2];
    logic pe [2];
    logic [31:0] ref_mem [2][64];
    int n_cmp = 0;
    int n_bad = 0;
    int lat_of [2] = '{2, 1};

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut0 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rr[0]), .req_addr(ra[0]),
        .req_wdata(rw[0]), .req_memcontrol(rc[0]), .resp_valid(pv[0]), .resp_rdata(pd[0]), .resp_err(pe[0])
    );
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rr[1]), .req_addr(ra[1]),
        .req_wdata(rw[1]), .req_memcontrol(rc[1]), .resp_valid(pv[1]), .resp_rdata(pd[1]), .resp_err(pe[1])
    );

    // Byte-oriented reference: split the word into bytes, gather/scatter size bytes from the offset.
    function automatic void model(input int u, input logic [3:0] code, input logic [31:0] addr,
                                  input logic [31:0] wdata, output logic [31:0] rd, output logic e);
        int w, o, size;
        logic [7:0] by [4];
        logic [31:0] v;
        w = int'(addr[7:2]);
        o = int'(addr[1:0]);
        for (int k = 0; k < 4; k++) by[k] = ref_mem[u][w][8*k +: 8];
        rd = 32'd0;
        e = 1'b0;
        if (code > 4'd7) begin
            e = 1'b1;
        end else begin
            size = (code == 4'd0 || code == 4'd5) ? 4 : (code == 4'd1 || code == 4'd2 || code == 4'd6) ? 2 : 1;
            if (o % size != 0) begin
                e = 1'b1;
            end else if (code < 4'd5) begin
                v = 32'd0;
                for (int k = 0; k < size; k++) v = v | (32'(by[o+k]) << (8*k));
                if (code == 4'd1 && v[15]) v = v | 32'hFFFF0000;
                if (code == 4'd3 && v[7]) v = v | 32'hFFFFFF00;
                rd = v;
            end else begin
                for (int k = 0; k < size; k++) by[o+k] = wdata[8*k +: 8];
                ref_mem[u][w] = {by[3], by[2], by[1], by[0]};
            end
        end
    endfunction

    // Issues one request from a negedge; returns response, cycles to response, cycles ready was low.
    task automatic req(input int u, input logic [3:0] code, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat, output int low,
                       output logic after_pv);
        int t;
        rv[u] = 1'b1;
        rc[u] = code;
        ra[u] = addr;
        rw[u] = wdata;
        t = 0;
        while (!rr[u] && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        @(negedge clk);
        rv[u] = 1'b0;
        lat = -1;
        low = 0;
        rdata = 32'hxxxxxxxx;
        err = 1'bx;
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) @(negedge clk);
            if (pv[u]) begin
                lat = k;
                rdata = pd[u];
                err = pe[u];
                break;
            end
            if (!rr[u]) low++;
        end
        @(negedge clk);
        after_pv = pv[u];
    endtask

    task automatic xact(input int u, input logic [3:0] code, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic e, output logic [31:0] xrd, output logic xe,
                        output int lat, output int low);
        logic ap;
        model(u, code, addr, wdata, xrd, xe);
        req(u, code, addr, wdata, rd, e, lat, low, ap);
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            n_cmp++;
            if ({rr[u], pv[u], pd[u], pe[u]} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
                n_bad++;
                $display("FAIL reset[%0d]: ready/valid/rdata/err got %b/%b/%h/%b want 1/0/0/0", u, rr[u], pv[u], pd[u], pe[u]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic init_mem();
        logic [31:0] rd, xrd;
        logic e, xe;
        int lat, low;
        for (int u = 0; u < 2; u++)
            for (int w = 0; w < 64; w++) begin
                ref_mem[u][w] = 32'd0;
                xact(u, 4'd5, 32'(w * 4), $urandom, rd, e, xrd, xe, lat, low);
            end
    endtask

    task automatic test_store_load();
        logic [31:0] rd, xrd;
        logic e, xe, ap;
        int lat, low;
        model(0, 4'd5, 32'h10, 32'hDEADBEEF, xrd, xe);
        req(0, 4'd5, 32'h10, 32'hDEADBEEF, rd, e, lat, low, ap);
        n_cmp++;
        if ({lat, low} !== {32'd2, 32'd2}) begin
            n_bad++;
            $display("FAIL sw_timing: latency %0d ready_low %0d want 2 2", lat, low);
        end
        n_cmp++;
        if ({rd, e} !== {32'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL sw_resp: rdata %h err %b want 0 0", rd, e);
        end
        model(0, 4'd0, 32'h10, 32'h0, xrd, xe);
        req(0, 4'd0, 32'h10, 32'h0, rd, e, lat, low, ap);
        n_cmp++;
        if ({rd, e} !== {32'hDEADBEEF, 1'b0}) begin
            n_bad++;
            $display("FAIL lw_data: rdata %h err %b want deadbeef 0", rd, e);
        end
        n_cmp++;
        if ({lat, low, ap} !== {32'd2, 32'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL lw_timing: latency %0d ready_low %0d pulse_after %b want 2 2 0", lat, low, ap);
        end
    endtask

    task automatic test_extend();
        logic [3:0] codes [4] = '{4'd3, 4'd4, 4'd1, 4'd2};
        logic [31:0] addrs [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
        logic [31:0] want [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
        logic [31:0] rd, xrd;
        logic e, xe;
        int lat, low;
        for (int i = 0; i < 4; i++) begin
            xact(0, codes[i], addrs[i], 32'h0, rd, e, xrd, xe, lat, low);
            n_cmp++;
            if ({rd, e} !== {want[i], 1'b0}) begin
                n_bad++;
                $display("FAIL extend code %0d addr %h: rdata %h err %b want %h 0", codes[i], addrs[i], rd, e, want[i]);
            end
        end
    endtask

    task automatic test_partial_store();
        logic [31:0] rd, xrd;
        logic e, xe;
        int lat, low;
        xact(0, 4'd7, 32'h11, 32'h12345655, rd, e, xrd, xe, lat, low);
        xact(0, 4'd6, 32'h12, 32'hAAAA7777, rd, e, xrd, xe, lat, low);
        xact(0, 4'd0, 32'h10, 32'h0, rd, e, xrd, xe, lat, low);
        n_cmp++;
        if (rd !== 32'h777755EF) begin
            n_bad++;
            $display("FAIL partial_store: rdata %h want 777755ef", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, xrd;
        logic e, xe;
        int lat, low;
        xact(0, 4'd0, 32'h11, 32'h0, rd, e, xrd, xe, lat, low);
        n_cmp++;
        if ({rd, e} !== {32'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL lw_misaligned: rdata %h err %b want 0 1", rd, e);
        end
        xact(0, 4'd6, 32'h13, 32'h55556666, rd, e, xrd, xe, lat, low);
        n_cmp++;
        if ({rd, e} !== {32'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL sh_misaligned: rdata %h err %b want 0 1", rd, e);
        end
        xact(0, 4'd0, 32'h10, 32'h0, rd, e, xrd, xe, lat, low);
        n_cmp++;
        if ({rd, e} !== {32'h777755EF, 1'b0}) begin
            n_bad++;
            $display("FAIL after_bad_sh: rdata %h err %b want 777755ef 0", rd, e);
        end
        xact(0, 4'b1010, 32'h10, 32'h0, rd, e, xrd, xe, lat, low);
        n_cmp++;
        if ({rd, e, lat} !== {32'd0, 1'b1, 32'd2}) begin
            n_bad++;
            $display("FAIL illegal_code: rdata %h err %b latency %0d want 0 1 2", rd, e, lat);
        end
    endtask

    task automatic test_back_to_back();
        int t [$];
        logic [31:0] d [$];
        int acc;
        bit drop;
        rv[0] = 1'b1;
        rc[0] = 4'd0;
        ra[0] = 32'h10;
        rw[0] = 32'h0;
        @(posedge clk);
        @(negedge clk);
        ra[0] = 32'h14;
        acc = 1;
        drop = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            if (pv[0]) begin
                t.push_back(i);
                d.push_back(pd[0]);
            end
            if (drop) begin
                rv[0] = 1'b0;
                drop = 0;
            end
            if (rv[0] && rr[0]) begin
                acc++;
                if (acc == 2) drop = 1;
            end
        end
        rv[0] = 1'b0;
        n_cmp++;
        if (t.size() != 2) begin
            n_bad++;
            $display("FAIL b2b_count: responses %0d want 2", t.size());
        end else begin
            n_cmp++;
            if (t[1] - t[0] != 3 || t[0] != 2) begin
                n_bad++;
                $display("FAIL b2b_spacing: first at %0d gap %0d want 2 3", t[0], t[1] - t[0]);
            end
            n_cmp++;
            if ({d[0], d[1]} !== {32'h777755EF, ref_mem[0][5]}) begin
                n_bad++;
                $display("FAIL b2b_data: got %h %h want 777755ef %h", d[0], d[1], ref_mem[0][5]);
            end
        end
    endtask

    task automatic test_reset_busy(input int u);
        logic [31:0] rd, xrd;
        logic e, xe;
        int lat, low, seen;
        rv[u] = 1'b1;
        rc[u] = 4'd5;
        ra[u] = 32'h20;
        rw[u] = 32'h1;
        @(posedge clk);
        @(negedge clk);
        rv[u] = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({rr[u], pv[u], pd[u], pe[u]} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL async_reset[%0d]: ready/valid/rdata/err got %b/%b/%h/%b want 1/0/0/0", u, rr[u], pv[u], pd[u], pe[u]);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (pv[u]) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL dropped_resp[%0d]: responses %0d want 0", u, seen);
        end
        xact(u, 4'd0, 32'h20, 32'h0, rd, e, xrd, xe, lat, low);
        n_cmp++;
        if ({rd, e, lat} !== {xrd, 1'b0, lat_of[u]}) begin
            n_bad++;
            $display("FAIL no_write_after_reset[%0d]: rdata %h err %b latency %0d want %h 0 %0d", u, rd, e, lat, xrd, lat_of[u]);
        end
    endtask

    task automatic test_random(input int u);
        logic [31:0] rd, xrd, addr;
        logic [3:0] code;
        logic e, xe;
        int lat, low;
        for (int i = 0; i < 150; i++) begin
            code = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) code = 4'($urandom_range(0, 7));
            addr = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 255));
            xact(u, code, addr, $urandom, rd, e, xrd, xe, lat, low);
            n_cmp++;
            if ({rd, e, lat, low} !== {xrd, xe, lat_of[u], lat_of[u]}) begin
                n_bad++;
                $display("FAIL random[%0d] #%0d code %0d addr %h: rdata %h err %b lat %0d low %0d want %h %b %0d %0d",
                         u, i, code, addr, rd, e, lat, low, xrd, xe, lat_of[u], lat_of[u]);
            end
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rv[u] = 1'b0;
            ra[u] = 32'd0;
            rw[u] = 32'd0;
            rc[u] = 4'd0;
        end
        test_reset();
        init_mem();
        test_store_load();
        test_extend();
        test_partial_store();
        test_errors();
        test_back_to_back();
        @(negedge clk);
        @(negedge clk);
        test_reset_busy(0);
        test_reset_busy(1);
        test_random(0);
        test_random(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
